mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Parametrised multicycle control unit for the MIPS-subset CPU datapath (PC, IR, MDR, register file, ALU, ALU_RES latch, unified data memory). Sequences each instruction through fetch, decode, execute, memory and writeback. Extends the fixed-latency controller with:
- a variable-latency memory handshake, with a timeout fault;
- an illegal-opcode fault;
- a retired-instruction counter.

It drives every datapath select and write-enable; it holds no datapath registers itself.

## Interface
Parameters:
- TIMEOUT, 15, max cycles a memory state waits for mem_ready before faulting (≥1)
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr  in  32  current IR contents
- alu_zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested
- mem_we  out  1  memory write (valid only with mem_req)
- mem_addr_sel  out  1  0=PC, 1=ALU_RES
- ir_we  out  1  IR load
- pc_we  out  1  PC load (includes branch condition)
- pc_src  out  2  0=A(Rs), 1=ALU_RES, 2=ALU result, 3=jump concat
- reg_we  out  1  register file write
- reg_dst  out  2  0=Rd, 1=Rt, 2=31
- reg_in  out  2  0=MDR, 1=ALU_RES, 2=PC
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=sext(imm16), 1=B, 2=4, 3=sext(imm16)<<2
- alu_op  out  2  0=ADD, 1=SUB, 2=XOR, 3=SLT
- state  out  4  current state encoding
- fault  out  1  sticky fault flag
- instret  out  RETIRE_W  retired-instruction count

## Operation
- Default for every output not listed for a state: 0.
- FETCH (0):
  - mem_req=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=2, alu_op=ADD, pc_src=2.
  - ir_we and pc_we equal mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE (1):
  - alu_src_a=0, alu_src_b=3, ADD. This computes the branch target into ALU_RES.
  - Next state by opcode instr[31:26]:
    - 0x00 with funct instr[5:0] 0x20/0x22/0x2A -> EXEC_R; funct 0x08 -> JR.
    - 0x23 and 0x2B -> ADDR.
    - 0x04 and 0x05 -> BRANCH.
    - 0x02 -> JUMP; 0x03 -> JAL.
    - 0x08 and 0x0E -> EXEC_I.
    - Anything else -> FAULT.
- EXEC_R (2): alu_src_a=1, alu_src_b=1; alu_op is ADD, SUB or SLT according to funct. Next: WB_R.
- WB_R (3): reg_we=1, reg_dst=0, reg_in=1. Retires. Next: FETCH.
- EXEC_I (4): alu_src_a=1, alu_src_b=0; alu_op ADD for 0x08, XOR for 0x0E. Next: WB_I.
- WB_I (5): reg_we=1, reg_dst=1, reg_in=1. Retires. Next: FETCH.
- ADDR (6): alu_src_a=1, alu_src_b=0, ADD. Next: MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD (7): mem_req=1, mem_addr_sel=1. MDR captures every cycle. On mem_ready go to WB_MEM.
- MEM_WR (8): mem_req=1, mem_we=1, mem_addr_sel=1. On mem_ready: retire, go to FETCH.
- WB_MEM (9): reg_we=1, reg_dst=1, reg_in=0. Retires. Next: FETCH.
- BRANCH (10):
  - alu_src_a=1, alu_src_b=1, SUB, pc_src=1.
  - pc_we = alu_zero for 0x04; pc_we = !alu_zero for 0x05.
  - Retires. Next: FETCH.
- JUMP (11): pc_src=3, pc_we=1. Retires. Next: FETCH.
- JAL (12): pc_src=3, pc_we=1, reg_we=1, reg_dst=2, reg_in=2. The register file samples the PC before the update. Retires. Next: FETCH.
- JR (13): pc_src=0, pc_we=1. Retires. Next: FETCH.
- FAULT (15): all outputs 0 except fault=1. Absorbing; only rst_n leaves it.
- Timeout:
  - A wait counter clears on entering FETCH, MEM_RD or MEM_WR, and increments each cycle that mem_ready=0.
  - If the counter equals TIMEOUT and mem_ready=0, the next state is FAULT.
  - If mem_ready=1 on that same cycle, the normal transition wins.
- Retire: instret increments by 1 on the clock edge that leaves a retiring cycle. It wraps from 2^RETIRE_W−1 to 0. It never increments in FAULT.

## Timing
- Reset (async, immediate): state=FETCH, fault=0, instret=0, wait counter=0.
  - Outputs take FETCH values during and after reset.
  - A mem_we asserted in MEM_WR drops combinationally when rst_n falls.
- Outputs are Moore functions of state, except:
  - ir_we and pc_we in FETCH, which depend on mem_ready;
  - pc_we in BRANCH, which depends on alu_zero.
- Latency with mem_ready always 1:
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Fault timing: FAULT is entered at most TIMEOUT+1 cycles after entering a memory state.

## Test plan
- Reset, then mem_ready=1 and instr=add $v1,$a0,$a1 (0x00851820) → states 0,1,2,3,0. WB_R has reg_we=1, reg_dst=0. instret=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD → states 0,1,6,7,7,7,7,9,0. mem_addr_sel=1 throughout MEM_RD. Total 8 cycles; instret increments once.
- beq with alu_zero=1 and then alu_zero=0; repeat with bne → pc_we=1 in BRANCH only when the condition holds, pc_src=1. Each takes 3 cycles.
- jal (opcode 0x03) → JAL cycle has pc_we=1, pc_src=3, reg_we=1, reg_dst=2, reg_in=2.
- TIMEOUT=15 with mem_ready held 0 in FETCH → FAULT after 16 cycles; fault=1 sticky, mem_req=0. Then rst_n low → state=0, fault=0, instret=0.
- Opcode 0x3F → FAULT from DECODE. Separately, mem_ready=1 on the exact cycle counter=TIMEOUT → DECODE, no fault. Separately, RETIRE_W=4 with 17 retirements → instret=1.

Source files
------------

// File: rtl/mc_control_unit_if.sv
// Control bundle between the multicycle control unit and the datapath.
// master: control unit (samples instr/alu_zero/mem_ready, drives selects/enables).
// slave : datapath/memory side.
interface mc_control_unit_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  reg_in;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           reg_we, reg_dst, reg_in, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
           reg_we, reg_dst, reg_in, alu_src_a, alu_src_b, alu_op
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit with variable-latency memory handshake,
// memory timeout fault, illegal-opcode fault and retired-instruction counter.
// Ports: clk, rst_n (async active-low), bus (datapath controls, master side),
//        state (current state), fault (sticky), instret (retired count).
module mc_control_unit #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_control_unit_if.master   bus,
  output logic [3:0]          state,
  output logic                fault,
  output logic [RETIRE_W-1:0] instret
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_SLT = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,  S_WB_I   = 4'd5,  S_ADDR   = 4'd6,  S_MEM_RD = 4'd7,
    S_MEM_WR = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_FAULT  = 4'd15
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic [RETIRE_W-1:0]   instret_q, instret_d;
  logic                  retire;
  logic                  mem_state;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];
  assign mem_state    = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);

  // State, wait counter and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_d          = state_q;
    retire           = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_src       = 2'd0;
    bus.reg_we       = 1'b0;
    bus.reg_dst      = 2'd0;
    bus.reg_in       = 2'd0;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = 2'd0;
    bus.alu_op       = OP_ADD;

    case (state_q)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'd2;
        bus.pc_src    = 2'd2;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (sext(imm)<<2) lands in ALU_RES
        bus.alu_src_b = 2'd3;
        case (opcode)
          6'h00: begin
            if (funct == 6'h20 || funct == 6'h22 || funct == 6'h2A) state_d = S_EXEC_R;
            else if (funct == 6'h08)                                 state_d = S_JR;
            else                                                     state_d = S_FAULT;
          end
          6'h23, 6'h2B: state_d = S_ADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h03:        state_d = S_JAL;
          6'h08, 6'h0E: state_d = S_EXEC_I;
          default:      state_d = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd1;
        case (funct)
          6'h22:   bus.alu_op = OP_SUB;
          6'h2A:   bus.alu_op = OP_SLT;
          default: bus.alu_op = OP_ADD;
        endcase
        state_d = S_WB_R;
      end
      S_WB_R: begin
        bus.reg_we = 1'b1;
        bus.reg_in = 2'd1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = (opcode == 6'h0E) ? OP_XOR : OP_ADD;
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 2'd1;
        bus.reg_in  = 2'd1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        state_d       = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_sel = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        bus.mem_req      = 1'b1;
        bus.mem_we       = 1'b1;
        bus.mem_addr_sel = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_MEM: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 2'd1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'd1;
        bus.alu_op    = OP_SUB;
        bus.pc_src    = 2'd1;
        bus.pc_we     = (opcode == 6'h04) ? bus.alu_zero : !bus.alu_zero;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src = 2'd3;
        bus.pc_we  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Register file writes the pre-update PC on the same edge as the jump
        bus.pc_src  = 2'd3;
        bus.pc_we   = 1'b1;
        bus.reg_we  = 1'b1;
        bus.reg_dst = 2'd2;
        bus.reg_in  = 2'd2;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JR: begin
        bus.pc_we = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Timeout only fires when the memory did not answer this cycle
    if (mem_state && !bus.mem_ready && wait_q == CNT_W'(TIMEOUT)) state_d = S_FAULT;

    if (state_d != state_q)           wait_d = '0;
    else if (mem_state && !bus.mem_ready) wait_d = wait_q + CNT_W'(1);
    else                              wait_d = wait_q;

    instret_d = retire ? instret_q + RETIRE_W'(1) : instret_q;
  end

  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle vector table plus hand-written
// sequences for reset, timeout, timeout rescue and counter wrap.
module tb_mc_control_unit;

  localparam logic [31:0] I_ADD  = 32'h0085_1820;
  localparam logic [31:0] I_SUB  = 32'h0085_1822;
  localparam logic [31:0] I_SLT  = 32'h0085_182A;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_LW   = 32'h8C82_0004;
  localparam logic [31:0] I_SW   = 32'hAC82_0008;
  localparam logic [31:0] I_BEQ  = 32'h1085_0003;
  localparam logic [31:0] I_BNE  = 32'h1485_0003;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_ADDI = 32'h2082_0005;
  localparam logic [31:0] I_XORI = 32'h3882_000F;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic        clk;
  logic        rst_n;
  logic        rst4_n;
  logic [3:0]  state, state4;
  logic        fault, fault4;
  logic [31:0] instret;
  logic [3:0]  instret4;
  int          total;
  int          bad;

  mc_control_unit_if bus ();
  mc_control_unit_if bus4 ();

  mc_control_unit #(.TIMEOUT(15), .RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .state(state), .fault(fault), .instret(instret)
  );

  mc_control_unit #(.TIMEOUT(15), .RETIRE_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4.master),
    .state(state4), .fault(fault4), .instret(instret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, reg_dst, reg_in, alu_src_a, alu_src_b, alu_op}
  logic [16:0] act_ctl;
  assign act_ctl = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
                    bus.pc_src, bus.reg_we, bus.reg_dst, bus.reg_in,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op};

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic        az;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        flt;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [31:0] instr, input logic mr, input logic az,
                             input logic [3:0] st, input logic mreq, input logic mwe,
                             input logic mas, input logic irwe, input logic pcwe,
                             input logic [1:0] pcsrc, input logic rwe, input logic [1:0] rdst,
                             input logic [1:0] rin, input logic asa, input logic [1:0] asb,
                             input logic [1:0] aop, input logic flt, input logic [31:0] ret);
    vec_t r;
    r.instr = instr; r.mr = mr; r.az = az; r.st = st; r.flt = flt; r.ret = ret;
    r.ctl   = {mreq, mwe, mas, irwe, pcwe, pcsrc, rwe, rdst, rin, asa, asb, aop};
    return r;
  endfunction

  // Fetch (mem_ready=1) followed by decode for one instruction
  task automatic fd(input logic [31:0] instr, input logic [31:0] ret);
    vecs.push_back(v(instr,1,0, 0, 1,0,0,1,1,2, 0,0,0, 0,2,0, 0,ret));
    vecs.push_back(v(instr,1,0, 1, 0,0,0,0,0,0, 0,0,0, 0,3,0, 0,ret));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;

    // add
    fd(I_ADD, 0);
    vecs.push_back(v(I_ADD,1,0, 2, 0,0,0,0,0,0, 0,0,0, 1,1,0, 0,0));
    vecs.push_back(v(I_ADD,1,0, 3, 0,0,0,0,0,0, 1,0,1, 0,0,0, 0,0));
    // lw with three wait cycles in MEM_RD
    fd(I_LW, 1);
    vecs.push_back(v(I_LW,1,0, 6, 0,0,0,0,0,0, 0,0,0, 1,0,0, 0,1));
    vecs.push_back(v(I_LW,0,0, 7, 1,0,1,0,0,0, 0,0,0, 0,0,0, 0,1));
    vecs.push_back(v(I_LW,0,0, 7, 1,0,1,0,0,0, 0,0,0, 0,0,0, 0,1));
    vecs.push_back(v(I_LW,0,0, 7, 1,0,1,0,0,0, 0,0,0, 0,0,0, 0,1));
    vecs.push_back(v(I_LW,1,0, 7, 1,0,1,0,0,0, 0,0,0, 0,0,0, 0,1));
    vecs.push_back(v(I_LW,1,0, 9, 0,0,0,0,0,0, 1,1,0, 0,0,0, 0,1));
    // sw
    fd(I_SW, 2);
    vecs.push_back(v(I_SW,1,0, 6, 0,0,0,0,0,0, 0,0,0, 1,0,0, 0,2));
    vecs.push_back(v(I_SW,1,0, 8, 1,1,1,0,0,0, 0,0,0, 0,0,0, 0,2));
    // beq taken / not taken, bne not taken / taken
    fd(I_BEQ, 3);
    vecs.push_back(v(I_BEQ,1,1,10, 0,0,0,0,1,1, 0,0,0, 1,1,1, 0,3));
    fd(I_BEQ, 4);
    vecs.push_back(v(I_BEQ,1,0,10, 0,0,0,0,0,1, 0,0,0, 1,1,1, 0,4));
    fd(I_BNE, 5);
    vecs.push_back(v(I_BNE,1,1,10, 0,0,0,0,0,1, 0,0,0, 1,1,1, 0,5));
    fd(I_BNE, 6);
    vecs.push_back(v(I_BNE,1,0,10, 0,0,0,0,1,1, 0,0,0, 1,1,1, 0,6));
    // jal, jr
    fd(I_JAL, 7);
    vecs.push_back(v(I_JAL,1,0,12, 0,0,0,0,1,3, 1,2,2, 0,0,0, 0,7));
    fd(I_JR, 8);
    vecs.push_back(v(I_JR,1,0,13, 0,0,0,0,1,0, 0,0,0, 0,0,0, 0,8));
    // addi, xori
    fd(I_ADDI, 9);
    vecs.push_back(v(I_ADDI,1,0, 4, 0,0,0,0,0,0, 0,0,0, 1,0,0, 0,9));
    vecs.push_back(v(I_ADDI,1,0, 5, 0,0,0,0,0,0, 1,1,1, 0,0,0, 0,9));
    fd(I_XORI, 10);
    vecs.push_back(v(I_XORI,1,0, 4, 0,0,0,0,0,0, 0,0,0, 1,0,2, 0,10));
    vecs.push_back(v(I_XORI,1,0, 5, 0,0,0,0,0,0, 1,1,1, 0,0,0, 0,10));
    // sub, slt
    fd(I_SUB, 11);
    vecs.push_back(v(I_SUB,1,0, 2, 0,0,0,0,0,0, 0,0,0, 1,1,1, 0,11));
    vecs.push_back(v(I_SUB,1,0, 3, 0,0,0,0,0,0, 1,0,1, 0,0,0, 0,11));
    fd(I_SLT, 12);
    vecs.push_back(v(I_SLT,1,0, 2, 0,0,0,0,0,0, 0,0,0, 1,1,3, 0,12));
    vecs.push_back(v(I_SLT,1,0, 3, 0,0,0,0,0,0, 1,0,1, 0,0,0, 0,12));
    // j
    fd(I_J, 13);
    vecs.push_back(v(I_J,1,0,11, 0,0,0,0,1,3, 0,0,0, 0,0,0, 0,13));
    // fetch stall, then illegal opcode into FAULT (absorbing)
    vecs.push_back(v(I_BAD,0,0, 0, 1,0,0,0,0,2, 0,0,0, 0,2,0, 0,14));
    fd(I_BAD, 14);
    vecs.push_back(v(I_BAD,1,0,15, 0,0,0,0,0,0, 0,0,0, 0,0,0, 1,14));
    vecs.push_back(v(I_BAD,0,1,15, 0,0,0,0,0,0, 0,0,0, 0,0,0, 1,14));

    // Reset: FETCH outputs visible while held in reset
    rst_n = 1'b0; rst4_n = 1'b0;
    bus.instr = I_ADD; bus.mem_ready = 1'b1; bus.alu_zero = 1'b0;
    bus4.instr = I_J; bus4.mem_ready = 1'b1; bus4.alu_zero = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset state", 32'(state), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset instret", instret, 32'd0);
    chk("reset ctl", 32'(act_ctl), 32'(17'b1_0_0_1_1_10_0_00_00_0_10_00));
    rst_n = 1'b1;

    // Vector table: one row per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      bus.instr     = vecs[i].instr;
      bus.mem_ready = vecs[i].mr;
      bus.alu_zero  = vecs[i].az;
      #1;
      chk($sformatf("row%0d state", i),   32'(state),   32'(vecs[i].st));
      chk($sformatf("row%0d ctl", i),     32'(act_ctl), 32'(vecs[i].ctl));
      chk($sformatf("row%0d fault", i),   32'(fault),   32'(vecs[i].flt));
      chk($sformatf("row%0d instret", i), instret,      vecs[i].ret);
      @(negedge clk);
    end

    // Async reset mid-cycle from FAULT
    #2 rst_n = 1'b0;
    #1;
    chk("async rst state", 32'(state), 32'd0);
    chk("async rst fault", 32'(fault), 32'd0);
    chk("async rst instret", instret, 32'd0);
    chk("async rst mem_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // mem_we drops immediately when reset hits MEM_WR
    bus.instr = I_SW; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("memwr state", 32'(state), 32'd8);
    chk("memwr mem_we", 32'(bus.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("memwr rst mem_we", 32'(bus.mem_we), 32'd0);
    chk("memwr rst state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FETCH timeout: FAULT after TIMEOUT+1 = 16 cycles
    bus.mem_ready = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (state == 4'd15) break;
    end
    chk("fetch timeout cycles", 32'(n), 32'd16);
    chk("fetch timeout fault", 32'(fault), 32'd1);
    chk("fetch timeout mem_req", 32'(bus.mem_req), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("fault sticky", 32'(fault), 32'd1);
    chk("fault sticky state", 32'(state), 32'd15);

    // mem_ready on the cycle counter==TIMEOUT wins over the timeout
    rst_n = 1'b0;
    #1;
    chk("rst after fault", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.instr = I_LW; bus.mem_ready = 1'b0;
    repeat (15) @(negedge clk);
    chk("rescue still fetch", 32'(state), 32'd0);
    bus.mem_ready = 1'b1;
    #1;
    chk("rescue ir_we", 32'(bus.ir_we), 32'd1);
    @(negedge clk);
    chk("rescue decode", 32'(state), 32'd1);
    chk("rescue no fault", 32'(fault), 32'd0);

    // MEM_RD timeout: counter restarts on entering MEM_RD
    bus.mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("memrd entered", 32'(state), 32'd7);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (state == 4'd15) break;
    end
    chk("memrd timeout cycles", 32'(n), 32'd16);
    chk("memrd timeout fault", 32'(fault), 32'd1);

    // RETIRE_W=4: 15, then wrap to 0 at 16, then 1 at 17 retirements
    rst4_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("w4 instret 15", 32'(instret4), 32'd15);
    repeat (3) @(negedge clk);
    chk("w4 instret wrap", 32'(instret4), 32'd0);
    chk("w4 state fetch", 32'(state4), 32'd0);
    repeat (3) @(negedge clk);
    chk("w4 instret 17", 32'(instret4), 32'd1);
    chk("w4 no fault", 32'(fault4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
